// File: rtl/add_minus_accum.sv
// add_minus_accum: valid/ready accumulator stage around a WIDTH-bit add/subtract datapath
// add_minus ports: a, b operands; m 0=add 1=subtract; s sum; c carry out; v signed overflow
// add_minus_accum ports: clk, rst_n (async, active low); in_valid/in_ready with in_b, in_m, in_load;
//   clr_sticky; out_valid/out_ready with acc, c_flag, v_flag, v_sticky
module add_minus #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v
);
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   full;
  assign bx   = b ^ {WIDTH{m}};
  // lo[WIDTH-1] is the carry into the MSB
  assign lo   = {1'b0, a[WIDTH-2:0]} + {1'b0, bx[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, m};
  assign full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, m};
  assign s    = full[WIDTH-1:0];
  assign c    = full[WIDTH];
  assign v    = full[WIDTH] ^ lo[WIDTH-1];
endmodule

module add_minus_accum #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_m,
  input  logic             in_load,
  input  logic             clr_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             c_flag,
  output logic             v_flag,
  output logic             v_sticky
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] s;
  logic c, v, accept, op_v;
  add_minus #(.WIDTH(WIDTH)) u_add_minus (.a(acc), .b(in_b), .m(in_m), .s(s), .c(c), .v(v));
  assign accept = in_valid & in_ready;
  assign op_v   = accept & ~in_load & v;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n   = IDLE;
    in_ready  = (state == IDLE) | out_ready;
    out_valid = state == HOLD;
    state_n   = (accept | (out_valid & ~out_ready)) ? HOLD : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc      <= '0;
      c_flag   <= 1'b0;
      v_flag   <= 1'b0;
      v_sticky <= 1'b0;
    end else begin
      if (accept) begin
        acc    <= in_load ? in_b : s;
        c_flag <= ~in_load & c;
        v_flag <= ~in_load & v;
      end
      // a coincident overflow outranks the clear
      v_sticky <= (v_sticky & ~clr_sticky) | op_v;
    end
endmodule

// File: tb/tb_add_minus_accum.sv
// tb_add_minus_accum: scoreboard bench for add_minus_accum against an arithmetic reference model
module tb_add_minus_accum;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_m = 0, in_load = 0, clr_sticky = 0, out_ready = 0;
  logic [3:0] in_b = 0;
  logic in_ready, out_valid, c_flag, v_flag, v_sticky;
  logic [3:0] acc;
  int tests = 0, fails = 0;
  typedef struct {logic [3:0] acc; logic c; logic v;} res_t;
  res_t q[$];
  logic m_hold = 0, m_sticky = 0;
  int m_acc = 0;
  add_minus_accum #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_b(in_b),
    .in_m(in_m), .in_load(in_load), .clr_sticky(clr_sticky), .out_valid(out_valid),
    .out_ready(out_ready), .acc(acc), .c_flag(c_flag), .v_flag(v_flag), .v_sticky(v_sticky)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [3:0] a, input logic [3:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic int sgn(input int x);
    return x >= 8 ? x - 16 : x;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 0; m_sticky = 0; m_acc = 0; q.delete();
    end else begin
      logic take;
      res_t r;
      int b, sr;
      take = in_valid && (!m_hold || out_ready);
      b = int'(in_b);
      if (clr_sticky) m_sticky = 0;
      if (take) begin
        if (in_load) begin
          r.acc = in_b; r.c = 0; r.v = 0;
        end else if (!in_m) begin
          sr = sgn(m_acc) + sgn(b);
          r.acc = 4'((m_acc + b) % 16); r.c = (m_acc + b) >= 16; r.v = sr > 7 || sr < -8;
        end else begin
          sr = sgn(m_acc) - sgn(b);
          r.acc = 4'((m_acc - b + 16) % 16); r.c = m_acc >= b; r.v = sr > 7 || sr < -8;
        end
        m_acc = int'(r.acc);
        if (r.v) m_sticky = 1;
        q.push_back(r);
      end
      m_hold = take || (m_hold && !out_ready);
    end
  end
  always @(negedge clk) begin
    chk("out_valid", {3'b0, out_valid}, {3'b0, m_hold});
    chk("in_ready", {3'b0, in_ready}, {3'b0, !m_hold || out_ready});
    chk("v_sticky", {3'b0, v_sticky}, {3'b0, m_sticky});
    if (m_hold) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL scoreboard: result presented with no expected entry at %0t", $time);
      end else begin
        chk("acc", acc, q[0].acc);
        chk("c_flag", {3'b0, c_flag}, {3'b0, q[0].c});
        chk("v_flag", {3'b0, v_flag}, {3'b0, q[0].v});
        if (out_ready) void'(q.pop_front());
      end
    end
  end
  task automatic beat(input logic ld, input logic m, input logic [3:0] b);
    in_valid = 1; in_load = ld; in_m = m; in_b = b;
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic res(input string n, input logic [3:0] a, input logic c, input logic v);
    chk({n, " acc"}, acc, a);
    chk({n, " c"}, {3'b0, c_flag}, {3'b0, c});
    chk({n, " v"}, {3'b0, v_flag}, {3'b0, v});
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    res("reset", 4'h0, 0, 0);
    chk("reset out_valid", {3'b0, out_valid}, 4'h0);
    chk("reset in_ready", {3'b0, in_ready}, 4'h1);
    chk("reset v_sticky", {3'b0, v_sticky}, 4'h0);
    rst_n = 1; out_ready = 1;
    beat(1, 0, 4'h7); beat(0, 0, 4'h1);
    res("add ovf", 4'h8, 0, 1);
    chk("add ovf sticky", {3'b0, v_sticky}, 4'h1);
    beat(1, 0, 4'hf); beat(0, 0, 4'hf);
    res("add carry", 4'he, 1, 0);
    chk("sticky held", {3'b0, v_sticky}, 4'h1);
    beat(1, 0, 4'h0); beat(0, 1, 4'hf);
    res("sub borrow", 4'h1, 0, 0);
    beat(1, 0, 4'hd); beat(0, 1, 4'ha);
    res("sub", 4'h3, 1, 0);
    beat(1, 0, 4'h7); beat(0, 1, 4'h8);
    res("sub ovf", 4'hf, 0, 1);
    beat(1, 0, 4'h5);
    out_ready = 0; in_valid = 1; in_load = 0; in_m = 0; in_b = 4'h1;
    repeat (3) begin
      @(posedge clk); #1;
      res("backpressure", 4'h5, 0, 0);
      chk("backpressure in_ready", {3'b0, in_ready}, 4'h0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    res("release", 4'h6, 0, 0);
    beat(1, 0, 4'h0);
    for (int i = 1; i <= 4; i++) begin
      beat(0, 0, 4'h1);
      chk("b2b acc", acc, 4'(i));
      chk("b2b out_valid", {3'b0, out_valid}, 4'h1);
    end
    beat(1, 0, 4'h7);
    clr_sticky = 1;
    beat(0, 0, 4'h1);
    clr_sticky = 0;
    chk("set wins", {3'b0, v_sticky}, 4'h1);
    clr_sticky = 1;
    @(posedge clk); #1;
    clr_sticky = 0;
    chk("clr sticky", {3'b0, v_sticky}, 4'h0);
    repeat (400) begin
      in_valid = 1'($urandom); in_load = ($urandom_range(0, 3) == 0); in_m = 1'($urandom);
      in_b = 4'($urandom); out_ready = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 9) == 0);
      @(posedge clk); #1;
    end
    in_valid = 0; clr_sticky = 0; out_ready = 1;
    beat(1, 0, 4'h9);
    out_ready = 0;
    #2;
    rst_n = 0;
    #1;
    chk("async rst out_valid", {3'b0, out_valid}, 4'h0);
    chk("async rst acc", acc, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/add_minus_accum.md
Name: add_minus_accum

Overview:
- Sequential accumulator stage wrapped around the 4-bit add/subtract datapath (add_minus), instantiated inside this block.
- Accepts operand/command beats on a valid/ready input and applies each to an internal accumulator: ACC ← ACC ± B, or ACC ← B.
- Presents the registered result, carry and overflow flags on a valid/ready output for the next stage (display/record logic).
- Supplies add_minus operands from its own register.

Parameters:
WIDTH, 4, datapath width in bits; must match the instantiated add_minus (4).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat present
in_ready  output  1  block can accept a beat this cycle
in_b  input  WIDTH  operand B
in_m  input  1  0 = add, 1 = subtract (drives add_minus m)
in_load  input  1  1 = load in_b into ACC, ignore in_m
clr_sticky  input  1  synchronous clear of v_sticky
out_valid  output  1  registered result valid
out_ready  input  1  consumer takes result
acc  output  WIDTH  accumulator value
c_flag  output  1  carry of last op (subtract: 1 = no borrow)
v_flag  output  1  signed overflow of last op
v_sticky  output  1  OR of v_flag over all ops since reset/clear

Behaviour:
- Reset (rst_n = 0, async):
  - state = IDLE; acc = 0; c_flag = 0; v_flag = 0; v_sticky = 0; out_valid = 0.
  - in_ready is combinational from state and is 1 in IDLE.
- Datapath: add_minus inputs are A = acc, B = in_b, m = in_m.
  - m = 0: S = A + B.
  - m = 1: S = A + ~B + 1.
  - c = carry out of bit WIDTH-1.
  - v = carry into MSB XOR carry out of MSB.
  - All arithmetic wraps modulo 2^WIDTH.
- States:
  - IDLE: out_valid = 0, in_ready = 1.
  - HOLD: out_valid = 1, in_ready = out_ready.
- Accept = in_valid & in_ready. On accept (registered at that clock edge):
  - in_load = 1: acc ← in_b; c_flag ← 0; v_flag ← 0.
  - in_load = 0: acc ← S; c_flag ← c; v_flag ← v; v_sticky ← v_sticky | v.
  - Next state is HOLD.
- Latency: result visible with out_valid = 1 exactly one cycle after accept.
- HOLD, out_ready = 0:
  - acc, c_flag, v_flag and out_valid held stable.
  - in_ready = 0; in_valid ignored, no state change.
- HOLD, out_ready = 1:
  - No new accept: next state is IDLE.
  - Accept in the same cycle: next state stays HOLD with the new result; the old result is consumed this edge.
  - Sustained throughput: 1 op/cycle.
- clr_sticky:
  - Clears v_sticky in any state.
  - If clr_sticky coincides with an accepted op having v = 1, v_sticky ends at 1 (set wins).
- in_load beats never set v_sticky.
- Reset asserted mid-HOLD: all outputs return to reset values immediately, and the pending result is discarded.
- in_b, in_m and in_load are sampled only on accept; their values in other cycles have no effect.

Test Plan:
1. Reset pulse -> acc=0000, out_valid=0, in_ready=1, c_flag=0, v_flag=0, v_sticky=0. Then hold out_ready=1 for all following steps unless stated.
2. Load 0111, then add 0001 (m=0) -> acc=1000, c=0, v=1, v_sticky=1. Follow with load 1111 and add 1111 -> acc=1110, c=1, v=0, v_sticky stays 1.
3. Load 0000, subtract 1111 (m=1) -> acc=0001, c=0, v=0. Load 1101, subtract 1010 -> acc=0011, c=1, v=0. Load 0111, subtract 1000 -> acc=1111, c=0, v=1.
4. Backpressure: after an accept, out_ready=0 for 3 cycles while in_valid=1 with in_b=0001 -> acc/flags unchanged, in_ready=0, no op applied. Then out_ready=1 -> the pending beat is accepted that cycle, and the new result appears the next cycle.
5. Back-to-back: load 0000, then four adds of 0001 on consecutive cycles with out_ready=1 -> acc reads 0001, 0010, 0011, 0100 on consecutive cycles; out_valid stays 1 throughout.
6. clr_sticky together with an overflowing add (acc=0111 + 0001) -> v_sticky=1. Then clr_sticky alone -> v_sticky=0. Assert rst_n=0 during HOLD -> out_valid=0 and acc=0000 immediately.
